// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared race FSM states and region field layout
package race_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RACING   = 2'd1,
    FINISHED = 2'd2
  } race_state_t;

  // Field index within a region word {x_min, x_max, y_min, y_max}, LSB first
  localparam int YMAX_IDX = 0;
  localparam int YMIN_IDX = 1;
  localparam int XMAX_IDX = 2;
  localparam int XMIN_IDX = 3;

  function automatic int reg_w(input int coord_w);
    return 4 * coord_w;
  endfunction

endpackage

// File: rtl/region_hit.sv
// rtl/region_hit.sv - inclusive unsigned bbox-inside-rectangle compare
module region_hit
  import race_pkg::*;
#(
  parameter int COORD_W = 11
) (
  input  logic [COORD_W-1:0]   x_start,
  input  logic [COORD_W-1:0]   x_end,
  input  logic [COORD_W-1:0]   y_start,
  input  logic [COORD_W-1:0]   y_end,
  input  logic [4*COORD_W-1:0] region,
  output logic                 hit
);

  logic [COORD_W-1:0] x_min, x_max, y_min, y_max;

  assign x_min = region[XMIN_IDX*COORD_W +: COORD_W];
  assign x_max = region[XMAX_IDX*COORD_W +: COORD_W];
  assign y_min = region[YMIN_IDX*COORD_W +: COORD_W];
  assign y_max = region[YMAX_IDX*COORD_W +: COORD_W];

  assign hit = (x_start >= x_min) && (x_end <= x_max) &&
               (y_start >= y_min) && (y_end <= y_max);

endmodule

// File: rtl/lap_tracker.sv
// rtl/lap_tracker.sv - per-car checkpoint, lap count and lap timing tracker
module lap_tracker
  import race_pkg::*;
#(
  parameter int NUM_CP  = 6,
  parameter int LAPS    = 3,
  parameter int ORDERED = 0,
  parameter int TIMER_W = 20,
  parameter int COORD_W = 11,
  localparam int LAP_W  = $clog2(LAPS + 1),
  localparam int REG_W  = reg_w(COORD_W)
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    tick,
  input  logic [COORD_W-1:0]      car_x_start,
  input  logic [COORD_W-1:0]      car_x_end,
  input  logic [COORD_W-1:0]      car_y_start,
  input  logic [COORD_W-1:0]      car_y_end,
  input  logic [NUM_CP*REG_W-1:0] cp_regions,
  input  logic [REG_W-1:0]        finish_region,
  output logic [NUM_CP-1:0]       cp_mask,
  output logic                    all_cp_passed,
  output logic                    lap_done,
  output logic                    lap_invalid,
  output logic [LAP_W-1:0]        lap_count,
  output logic                    race_active,
  output logic                    race_finished,
  output logic [TIMER_W-1:0]      lap_time,
  output logic [TIMER_W-1:0]      last_lap_time,
  output logic [TIMER_W-1:0]      best_lap_time
);

  localparam logic [LAP_W-1:0] LAST_LAP = LAP_W'(LAPS - 1);

  race_state_t         state;
  logic [NUM_CP-1:0]   cp_hit;
  logic [NUM_CP-1:0]   cp_set;
  logic                fin_hit;
  logic                fin_prev;
  logic                fin_rise;
  logic                mask_full;
  logic [TIMER_W-1:0]  lap_time_inc;

  for (genvar i = 0; i < NUM_CP; i++) begin : g_cp
    region_hit #(.COORD_W(COORD_W)) u_cp_hit (
      .x_start (car_x_start),
      .x_end   (car_x_end),
      .y_start (car_y_start),
      .y_end   (car_y_end),
      .region  (cp_regions[i*REG_W +: REG_W]),
      .hit     (cp_hit[i])
    );
  end

  region_hit #(.COORD_W(COORD_W)) u_fin_hit (
    .x_start (car_x_start),
    .x_end   (car_x_end),
    .y_start (car_y_start),
    .y_end   (car_y_end),
    .region  (finish_region),
    .hit     (fin_hit)
  );

  // (mask + 1) & ~mask isolates the lowest clear bit: the next checkpoint due
  always_comb begin
    cp_set = cp_hit;
    if (ORDERED != 0) cp_set = cp_hit & ~cp_mask & (cp_mask + NUM_CP'(1));
  end

  assign fin_rise     = fin_hit & ~fin_prev;
  assign mask_full    = &cp_mask;
  assign lap_time_inc = (tick && !(&lap_time)) ? lap_time + TIMER_W'(1) : lap_time;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state         <= IDLE;
      cp_mask       <= '0;
      all_cp_passed <= 1'b0;
      lap_done      <= 1'b0;
      lap_invalid   <= 1'b0;
      lap_count     <= '0;
      race_active   <= 1'b0;
      race_finished <= 1'b0;
      lap_time      <= '0;
      last_lap_time <= '0;
      best_lap_time <= '1;
      fin_prev      <= 1'b0;
    end else begin
      lap_done      <= 1'b0;
      lap_invalid   <= 1'b0;
      fin_prev      <= fin_hit;
      all_cp_passed <= mask_full;
      if (start) begin
        state         <= RACING;
        race_active   <= 1'b1;
        race_finished <= 1'b0;
        cp_mask       <= '0;
        lap_count     <= '0;
        lap_time      <= '0;
        last_lap_time <= '0;
        best_lap_time <= '1;
      end else if (state == RACING) begin
        if (fin_rise && mask_full) begin
          lap_done      <= 1'b1;
          lap_count     <= lap_count + LAP_W'(1);
          cp_mask       <= '0;
          lap_time      <= '0;
          last_lap_time <= lap_time_inc;
          if (lap_time_inc < best_lap_time) best_lap_time <= lap_time_inc;
          if (lap_count == LAST_LAP) begin
            state         <= FINISHED;
            race_active   <= 1'b0;
            race_finished <= 1'b1;
          end
        end else begin
          lap_invalid <= fin_rise;
          cp_mask     <= cp_mask | cp_set;
          lap_time    <= lap_time_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lap_tracker.sv
// tb/tb_lap_tracker.sv - directed self-checking bench for lap_tracker
module tb_lap_tracker;

  localparam int NCP = 6;
  localparam int CW  = 11;
  localparam int TW  = 20;
  localparam int RW  = 4 * CW;

  logic pclk = 1'b0;
  logic rst, start, tick;
  logic [CW-1:0] car_x_start, car_x_end, car_y_start, car_y_end;
  logic [NCP*RW-1:0] cp_regions;
  logic [RW-1:0] finish_region;

  logic [NCP-1:0] mask_u, mask_o;
  logic all_u, all_o, done_u, done_o, inv_u, inv_o;
  logic [1:0] cnt_u, cnt_o;
  logic act_u, act_o, fin_u, fin_o;
  logic [TW-1:0] lt_u, lt_o, last_u, last_o, best_u, best_o;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  lap_tracker #(.NUM_CP(NCP), .LAPS(3), .ORDERED(0), .TIMER_W(TW), .COORD_W(CW)) dut_u (
    .pclk(pclk), .rst(rst), .start(start), .tick(tick),
    .car_x_start(car_x_start), .car_x_end(car_x_end),
    .car_y_start(car_y_start), .car_y_end(car_y_end),
    .cp_regions(cp_regions), .finish_region(finish_region),
    .cp_mask(mask_u), .all_cp_passed(all_u), .lap_done(done_u), .lap_invalid(inv_u),
    .lap_count(cnt_u), .race_active(act_u), .race_finished(fin_u),
    .lap_time(lt_u), .last_lap_time(last_u), .best_lap_time(best_u)
  );

  lap_tracker #(.NUM_CP(NCP), .LAPS(3), .ORDERED(1), .TIMER_W(TW), .COORD_W(CW)) dut_o (
    .pclk(pclk), .rst(rst), .start(start), .tick(tick),
    .car_x_start(car_x_start), .car_x_end(car_x_end),
    .car_y_start(car_y_start), .car_y_end(car_y_end),
    .cp_regions(cp_regions), .finish_region(finish_region),
    .cp_mask(mask_o), .all_cp_passed(all_o), .lap_done(done_o), .lap_invalid(inv_o),
    .lap_count(cnt_o), .race_active(act_o), .race_finished(fin_o),
    .lap_time(lt_o), .last_lap_time(last_o), .best_lap_time(best_o)
  );

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic place(input int x, input int y);
    car_x_start = CW'(x);
    car_x_end   = CW'(x + 10);
    car_y_start = CW'(y);
    car_y_end   = CW'(y + 10);
  endtask

  task automatic park();
    place(1500, 1500);
  endtask

  task automatic visit_cp(input int i);
    place(i * 100 + 20, 150);
    step();
    park();
    step();
  endtask

  task automatic on_finish();
    place(20, 350);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mask_u !== 6'h00) begin errors++; $display("FAIL reset_mask got %h want 00", mask_u); end
    checks++; if (cnt_u !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt_u); end
    checks++; if (act_u !== 1'b0 || fin_u !== 1'b0) begin errors++; $display("FAIL reset_state got act=%b fin=%b want 0 0", act_u, fin_u); end
    checks++; if (best_u !== 20'hFFFFF) begin errors++; $display("FAIL reset_best got %h want fffff", best_u); end
    checks++; if (lt_u !== 20'd0 || last_u !== 20'd0) begin errors++; $display("FAIL reset_times got %0d %0d want 0 0", lt_u, last_u); end
    checks++; if (done_u !== 1'b0 || inv_u !== 1'b0 || all_u !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b want 000", done_u, inv_u, all_u); end
  endtask

  task automatic test_invalid_lap();
    visit_cp(0);
    checks++; if (mask_u !== 6'h00) begin errors++; $display("FAIL idle_ignores_hits got %h want 00", mask_u); end
    pulse_start();
    checks++; if (act_u !== 1'b1) begin errors++; $display("FAIL start_active got %b want 1", act_u); end
    on_finish();
    step();
    checks++; if (inv_u !== 1'b1) begin errors++; $display("FAIL invalid_pulse got %b want 1", inv_u); end
    checks++; if (cnt_u !== 2'd0 || mask_u !== 6'h00) begin errors++; $display("FAIL invalid_state got cnt=%0d mask=%h want 0 00", cnt_u, mask_u); end
    step();
    checks++; if (inv_u !== 1'b0) begin errors++; $display("FAIL invalid_one_cycle got %b want 0", inv_u); end
    park();
    step();
  endtask

  task automatic test_unordered();
    int order [6] = '{5, 2, 0, 1, 3, 4};
    for (int k = 0; k < 6; k++) visit_cp(order[k]);
    checks++; if (mask_u !== 6'h3F) begin errors++; $display("FAIL unord_mask got %h want 3f", mask_u); end
    checks++; if (all_u !== 1'b1) begin errors++; $display("FAIL unord_all got %b want 1", all_u); end
    checks++; if (mask_o !== 6'h03) begin errors++; $display("FAIL ord_partial_mask got %h want 03", mask_o); end
    on_finish();
    step();
    checks++; if (done_u !== 1'b1 || cnt_u !== 2'd1 || mask_u !== 6'h00) begin errors++; $display("FAIL unord_lap got done=%b cnt=%0d mask=%h want 1 1 00", done_u, cnt_u, mask_u); end
    checks++; if (inv_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL ord_incomplete got inv=%b done=%b want 1 0", inv_o, done_o); end
    park();
    step();
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL unord_done_one_cycle got %b want 0", done_u); end
  endtask

  task automatic test_ordered();
    pulse_start();
    visit_cp(1);
    visit_cp(0);
    checks++; if (mask_o !== 6'h01) begin errors++; $display("FAIL ord_skip got %h want 01", mask_o); end
    for (int i = 1; i < 6; i++) visit_cp(i);
    checks++; if (mask_o !== 6'h3F) begin errors++; $display("FAIL ord_full got %h want 3f", mask_o); end
    on_finish();
    step();
    checks++; if (done_o !== 1'b1 || cnt_o !== 2'd1) begin errors++; $display("FAIL ord_lap got done=%b cnt=%0d want 1 1", done_o, cnt_o); end
    park();
    step();
  endtask

  task automatic test_timing();
    pulse_start();
    for (int i = 0; i < 6; i++) visit_cp(i);
    run_ticks(100);
    checks++; if (lt_u !== 20'd100) begin errors++; $display("FAIL lap1_running got %0d want 100", lt_u); end
    on_finish();
    step();
    checks++; if (last_u !== 20'd100 || best_u !== 20'd100 || lt_u !== 20'd0) begin errors++; $display("FAIL lap1_time got last=%0d best=%0d lt=%0d want 100 100 0", last_u, best_u, lt_u); end
    park();
    step();
    for (int i = 0; i < 6; i++) visit_cp(i);
    run_ticks(79);
    on_finish();
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++; if (last_u !== 20'd80 || best_u !== 20'd80 || lt_u !== 20'd0) begin errors++; $display("FAIL lap2_tick_fold got last=%0d best=%0d lt=%0d want 80 80 0", last_u, best_u, lt_u); end
    checks++; if (cnt_u !== 2'd2 || last_o !== 20'd80) begin errors++; $display("FAIL lap2_count got cnt=%0d last_o=%0d want 2 80", cnt_u, last_o); end
    park();
    step();
  endtask

  task automatic test_race_finish();
    for (int i = 0; i < 6; i++) visit_cp(i);
    run_ticks(90);
    on_finish();
    step();
    checks++; if (fin_u !== 1'b1 || act_u !== 1'b0 || cnt_u !== 2'd3) begin errors++; $display("FAIL finish_state got fin=%b act=%b cnt=%0d want 1 0 3", fin_u, act_u, cnt_u); end
    checks++; if (last_u !== 20'd90 || best_u !== 20'd80) begin errors++; $display("FAIL finish_times got last=%0d best=%0d want 90 80", last_u, best_u); end
    park();
    step();
    visit_cp(0);
    run_ticks(5);
    on_finish();
    step();
    checks++; if (done_u !== 1'b0 || inv_u !== 1'b0 || mask_u !== 6'h00) begin errors++; $display("FAIL frozen_pulses got done=%b inv=%b mask=%h want 0 0 00", done_u, inv_u, mask_u); end
    checks++; if (lt_u !== 20'd0 || cnt_u !== 2'd3 || last_u !== 20'd90) begin errors++; $display("FAIL frozen_counters got lt=%0d cnt=%0d last=%0d want 0 3 90", lt_u, cnt_u, last_u); end
    park();
    step();
    pulse_start();
    checks++; if (act_u !== 1'b1 || fin_u !== 1'b0 || cnt_u !== 2'd0) begin errors++; $display("FAIL restart_state got act=%b fin=%b cnt=%0d want 1 0 0", act_u, fin_u, cnt_u); end
    checks++; if (best_u !== 20'hFFFFF || last_u !== 20'd0) begin errors++; $display("FAIL restart_times got best=%h last=%0d want fffff 0", best_u, last_u); end
  endtask

  task automatic test_parked_and_reset();
    on_finish();
    step();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (inv_u !== 1'b0 || done_u !== 1'b0) begin errors++; $display("FAIL parked_no_pulse cycle %0d got inv=%b done=%b want 0 0", k, inv_u, done_u); end
    end
    park();
    step();
    on_finish();
    step();
    checks++; if (inv_u !== 1'b1) begin errors++; $display("FAIL reentry_invalid got %b want 1", inv_u); end
    park();
    step();
    visit_cp(0);
    run_ticks(7);
    checks++; if (mask_u !== 6'h01 || lt_u !== 20'd7) begin errors++; $display("FAIL midlap got mask=%h lt=%0d want 01 7", mask_u, lt_u); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mask_u !== 6'h00 || lt_u !== 20'd0 || act_u !== 1'b0 || best_u !== 20'hFFFFF) begin errors++; $display("FAIL midlap_reset got mask=%h lt=%0d act=%b best=%h want 00 0 0 fffff", mask_u, lt_u, act_u, best_u); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    park();
    for (int i = 0; i < NCP; i++)
      cp_regions[i*RW +: RW] = {CW'(i * 100), CW'(i * 100 + 90), CW'(100), CW'(200)};
    finish_region = {CW'(0), CW'(90), CW'(300), CW'(400)};
    test_reset();
    test_invalid_lap();
    test_unordered();
    test_ordered();
    test_timing();
    test_race_finish();
    test_parked_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
